// File: rtl/fir_pack_pkg.sv
// Shared types and constants for the FIR TDM output packer.
// FSM encodings, channel tags, default widths and saturation-limit helpers.
package fir_pack_pkg;

  localparam int unsigned DEF_DATA_W     = 24;
  localparam int unsigned DEF_OUT_W      = 16;
  localparam int unsigned DEF_SHIFT      = 8;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CH1  = 2'd1,
    ST_CH2  = 2'd2,
    ST_CH3  = 2'd3
  } state_t;

  localparam logic [1:0] CHAN_NONE = 2'd0;
  localparam logic [1:0] CHAN_1    = 2'd1;
  localparam logic [1:0] CHAN_2    = 2'd2;
  localparam logic [1:0] CHAN_3    = 2'd3;

  // Largest / smallest signed value representable in w bits.
  function automatic int sat_max(input int unsigned w);
    return (2 ** (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int unsigned w);
    return -(2 ** (w - 1));
  endfunction

endpackage

// File: rtl/fir_pack_fifo.sv
// Synchronous frame FIFO with extra-MSB pointers for full/empty detection.
// Exposes the head entry and a low-slice peek of the entry behind it.
module fir_pack_fifo #(
  parameter int unsigned WIDTH  = 48,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PEEK_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          head_c,
  output logic [PEEK_W-1:0]         next_head_c,
  output logic                      full_c,
  output logic                      empty_c,
  output logic [$clog2(DEPTH):0]    count_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW-1:0]    rd_idx_next;
  logic             do_wr;
  logic             do_rd;

  assign do_wr       = wr_en && !full_c;
  assign do_rd       = rd_en && !empty_c;
  assign rd_idx_next = rd_ptr[AW-1:0] + AW'(1);

  assign count_c     = wr_ptr - rd_ptr;
  assign empty_c     = (wr_ptr == rd_ptr);
  assign full_c      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_c      = mem[rd_ptr[AW-1:0]];
  assign next_head_c = mem[rd_idx_next][PEEK_W-1:0];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/fir_tdm_output_packer.sv
// Scales/saturates 3-channel FIR frames, buffers them and streams them as ch1,ch2,ch3 beats.
// Optional FIR_PACK_DROP_CNT_EN adds a saturating count of frames dropped on a full FIFO.
module fir_tdm_output_packer
  import fir_pack_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned OUT_W      = DEF_OUT_W,
  parameter int unsigned SHIFT      = DEF_SHIFT,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  input  logic [DATA_W-1:0] in_data3,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [1:0]        out_chan,
  output logic              out_last,
  output logic              sat_sticky
`ifdef FIR_PACK_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int unsigned FRAME_W = 3 * OUT_W;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic signed [DATA_W:0] SAT_HI = (DATA_W+1)'(sat_max(OUT_W));
  localparam logic signed [DATA_W:0] SAT_LO = (DATA_W+1)'(sat_min(OUT_W));
  localparam logic signed [DATA_W:0] ROUND  = (DATA_W+1)'(2 ** (SHIFT - 1));

  // Returns {clamped, sample}: round-half-up shift, then clamp to OUT_W.
  function automatic logic [OUT_W:0] scale_sat(input logic [DATA_W-1:0] x);
    logic signed [DATA_W:0] y;
    y = ($signed({x[DATA_W-1], x}) + ROUND) >>> SHIFT;
    if (y > SAT_HI)      scale_sat = {1'b1, SAT_HI[OUT_W-1:0]};
    else if (y < SAT_LO) scale_sat = {1'b1, SAT_LO[OUT_W-1:0]};
    else                 scale_sat = {1'b0, y[OUT_W-1:0]};
  endfunction

  logic [OUT_W:0]     s1, s2, s3;
  logic [FRAME_W-1:0] frame;
  logic               any_clamp;
  logic               wr_fire;
  logic               pop;
  logic [FRAME_W-1:0] head;
  logic [OUT_W-1:0]   next_ch1;
  logic               full;
  logic               empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   count_next;

  state_t             state_q, state_d;
  logic               valid_d;
  logic [OUT_W-1:0]   data_d;
  logic [1:0]         chan_d;
  logic               last_d;

  always_comb begin
    s1        = scale_sat(in_data1);
    s2        = scale_sat(in_data2);
    s3        = scale_sat(in_data3);
    frame     = {s3[OUT_W-1:0], s2[OUT_W-1:0], s1[OUT_W-1:0]};
    any_clamp = s1[OUT_W] | s2[OUT_W] | s3[OUT_W];
  end

  assign wr_fire    = in_valid && !full;
  assign count_next = fifo_count + CNT_W'(wr_fire) - CNT_W'(pop);

  fir_pack_fifo #(
    .WIDTH  (FRAME_W),
    .DEPTH  (FIFO_DEPTH),
    .PEEK_W (OUT_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (in_valid),
    .wr_data     (frame),
    .rd_en       (pop),
    .head_c      (head),
    .next_head_c (next_ch1),
    .full_c      (full),
    .empty_c     (empty),
    .count_c     (fifo_count)
  );

  // Next-state and next-output logic; outputs are loaded on the transition into each state.
  always_comb begin
    state_d = state_q;
    valid_d = out_valid;
    data_d  = out_data;
    chan_d  = out_chan;
    last_d  = out_last;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          state_d = ST_CH1;
          valid_d = 1'b1;
          data_d  = head[OUT_W-1:0];
          chan_d  = CHAN_1;
          last_d  = 1'b0;
        end
      end
      ST_CH1: begin
        if (out_ready) begin
          state_d = ST_CH2;
          data_d  = head[2*OUT_W-1:OUT_W];
          chan_d  = CHAN_2;
        end
      end
      ST_CH2: begin
        if (out_ready) begin
          state_d = ST_CH3;
          data_d  = head[3*OUT_W-1:2*OUT_W];
          chan_d  = CHAN_3;
          last_d  = 1'b1;
        end
      end
      ST_CH3: begin
        if (out_ready) begin
          pop = 1'b1;
          if (fifo_count > CNT_W'(1)) begin
            state_d = ST_CH1;
            data_d  = next_ch1;
            chan_d  = CHAN_1;
            last_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            data_d  = '0;
            chan_d  = CHAN_NONE;
            last_d  = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= CHAN_NONE;
      out_last  <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= valid_d;
      out_data  <= data_d;
      out_chan  <= chan_d;
      out_last  <= last_d;
    end
  end

  // in_ready reflects occupancy after this edge, so it is low in reset and high one clock after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready   <= 1'b0;
      sat_sticky <= 1'b0;
    end else begin
      in_ready <= (count_next != CNT_W'(FIFO_DEPTH));
      if (wr_fire && any_clamp) sat_sticky <= 1'b1;
    end
  end

`ifdef FIR_PACK_DROP_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (in_valid && full && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule
